// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared types, pointer widths and round-robin helper for wb_arbiter
package wb_arbiter_pkg;

  // Largest supported source count; the RR pointer is sized for it
  localparam int MAX_SRC        = 8;
  localparam int RR_PTR_W       = $clog2(MAX_SRC);
  localparam int DEF_FIFO_DEPTH = 2;
  // One extra MSB so full and empty can be told apart when the indices match
  localparam int FIFO_PTR_W     = $clog2(DEF_FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_entry_t;

  // Next scan start: one past the last source granted in scan order, or unchanged if none
  function automatic logic [RR_PTR_W-1:0] rr_next(
    input logic [RR_PTR_W-1:0] ptr,
    input logic [MAX_SRC-1:0]  grant_mask,
    input int                  num_src
  );
    int   last;
    int   idx;
    logic any;
    last = 0;
    idx  = 0;
    any  = 1'b0;
    for (int k = 0; k < MAX_SRC; k++) begin
      if (k < num_src) begin
        idx = (int'(ptr) + k) % num_src;
        for (int j = 0; j < MAX_SRC; j++) begin
          if (j == idx && grant_mask[j]) begin
            last = j;
            any  = 1'b1;
          end
        end
      end
    end
    if (any) rr_next = RR_PTR_W'((last + 1) % num_src);
    else     rr_next = ptr;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - per-source in-order write-back FIFO with flush and per-slot valid/address export
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH  = DEF_FIFO_DEPTH,
  parameter int PTR_W  = FIFO_PTR_W,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [ADDR_W-1:0]       push_addr,
  input  logic [DATA_W-1:0]       push_data,
  output logic [ADDR_W-1:0]       head_addr,
  output logic [DATA_W-1:0]       head_data,
  output logic                    full,
  output logic                    empty,
  output logic [DEPTH-1:0]        slot_valid,
  output logic [DEPTH*ADDR_W-1:0] slot_addr
);

  localparam int IDX_W = PTR_W - 1;

  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [PTR_W-1:0]  count;
  logic [IDX_W-1:0]  off;
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  assign empty     = (wptr == rptr);
  assign full      = (wptr[PTR_W-1] != rptr[PTR_W-1]) && (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]);
  assign count     = wptr - rptr;
  assign head_addr = mem_addr[rptr[IDX_W-1:0]];
  assign head_data = mem_data[rptr[IDX_W-1:0]];

  // Pointer update; flush wins over push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)  wptr <= wptr + PTR_W'(1);
      if (pop  && !empty) rptr <= rptr + PTR_W'(1);
    end
  end

  // Entry storage needs no reset: the pointers define what is valid
  always_ff @(posedge clk) begin
    if (push && !full && !flush) begin
      mem_addr[wptr[IDX_W-1:0]] <= push_addr;
      mem_data[wptr[IDX_W-1:0]] <= push_data;
    end
  end

  // A slot is live when its distance from the read index is below the fill count
  always_comb begin
    slot_valid = '0;
    slot_addr  = '0;
    off        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off           = IDX_W'(i) - rptr[IDX_W-1:0];
      slot_valid[i] = ({1'b0, off} < count);
      slot_addr[i*ADDR_W +: ADDR_W] = mem_addr[i];
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin write-back arbiter; WB_ARBITER_BYPASS_EN enables zero-latency bypass
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int NUM_WPORT  = 1,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush_i,
  input  logic [NUM_SRC-1:0]          src_valid_i,
  output logic [NUM_SRC-1:0]          src_ready_o,
  input  logic [NUM_SRC*ADDR_W-1:0]   src_waddr_i,
  input  logic [NUM_SRC*DATA_W-1:0]   src_wdata_i,
  output logic [NUM_WPORT-1:0]        reg_we_o,
  output logic [NUM_WPORT*ADDR_W-1:0] reg_waddr_o,
  output logic [NUM_WPORT*DATA_W-1:0] reg_wdata_o,
  output logic [2**ADDR_W-1:0]        pending_o,
  output logic                        full_o
);

  localparam int NREG = 2**ADDR_W;

  logic [NUM_SRC-1:0]           full;
  logic [NUM_SRC-1:0]           empty;
  logic [NUM_SRC-1:0]           req;
  logic [NUM_SRC-1:0]           push;
  logic [NUM_SRC-1:0]           pop;
  logic [NUM_SRC-1:0]           cand;
  logic [NUM_SRC-1:0]           byp_cand;
  logic [NUM_SRC-1:0]           grant;
  logic [ADDR_W-1:0]            head_addr  [NUM_SRC];
  logic [DATA_W-1:0]            head_data  [NUM_SRC];
  logic [ADDR_W-1:0]            cand_addr  [NUM_SRC];
  logic [DATA_W-1:0]            cand_data  [NUM_SRC];
  logic [FIFO_DEPTH-1:0]        slot_valid [NUM_SRC];
  logic [FIFO_DEPTH*ADDR_W-1:0] slot_addr  [NUM_SRC];
  logic [NREG-1:0]              seen;
  logic [RR_PTR_W-1:0]          rr_ptr;
  int                           idx;
  int                           nport;

`ifdef WB_ARBITER_BYPASS_EN
  // An incoming write may go straight to a port when its FIFO is empty; never during flush or reset
  assign byp_cand = empty & req & {NUM_SRC{~flush_i & rst_n}};
`else
  assign byp_cand = '0;
`endif

  assign cand        = ~empty | byp_cand;
  assign pop         = grant & ~empty;
  assign src_ready_o = ~full;
  assign full_o      = |full;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    // Writes to x0 are accepted but never stored
    assign req[s]       = src_valid_i[s] && (src_waddr_i[s*ADDR_W +: ADDR_W] != '0);
    assign push[s]      = req[s] && !full[s] && !flush_i && !(grant[s] && empty[s]);
    assign cand_addr[s] = empty[s] ? src_waddr_i[s*ADDR_W +: ADDR_W] : head_addr[s];
    assign cand_data[s] = empty[s] ? src_wdata_i[s*DATA_W +: DATA_W] : head_data[s];

    wb_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .PTR_W  ($clog2(FIFO_DEPTH) + 1),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push[s]),
      .pop        (pop[s]),
      .flush      (flush_i),
      .push_addr  (src_waddr_i[s*ADDR_W +: ADDR_W]),
      .push_data  (src_wdata_i[s*DATA_W +: DATA_W]),
      .head_addr  (head_addr[s]),
      .head_data  (head_data[s]),
      .full       (full[s]),
      .empty      (empty[s]),
      .slot_valid (slot_valid[s]),
      .slot_addr  (slot_addr[s])
    );
  end

  // Scan from the RR pointer; a register claimed by an earlier candidate blocks later ones
  always_comb begin
    grant       = '0;
    reg_we_o    = '0;
    reg_waddr_o = '0;
    reg_wdata_o = '0;
    seen        = '0;
    nport       = 0;
    idx         = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_SRC;
      for (int s = 0; s < NUM_SRC; s++) begin
        if (s == idx && cand[s]) begin
          if (!flush_i && !seen[cand_addr[s]] && nport < NUM_WPORT) begin
            grant[s] = 1'b1;
            for (int p = 0; p < NUM_WPORT; p++) begin
              if (p == nport) begin
                reg_we_o[p]                    = 1'b1;
                reg_waddr_o[p*ADDR_W +: ADDR_W] = cand_addr[s];
                reg_wdata_o[p*DATA_W +: DATA_W] = cand_data[s];
              end
            end
            nport = nport + 1;
          end
          seen[cand_addr[s]] = 1'b1;
        end
      end
    end
  end

  // Pending mask covers every stored entry, including heads being written this cycle
  always_comb begin
    pending_o = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (slot_valid[s][i]) pending_o[slot_addr[s][i*ADDR_W +: ADDR_W]] = 1'b1;
      end
    end
    pending_o[0] = 1'b0;
  end

  // Round-robin pointer advances past the last granted source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr <= '0;
    else        rr_ptr <= rr_next(rr_ptr, MAX_SRC'(grant), NUM_SRC);
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed bench for wb_arbiter (1-port and 2-port instances; WB_ARBITER_BYPASS_EN aware)
module tb_wb_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;

  logic         flush1, flush2;
  logic [3:0]   v1, v2, rdy1, rdy2;
  logic [19:0]  a1, a2;
  logic [127:0] d1, d2;
  logic [0:0]   we1;
  logic [1:0]   we2;
  logic [4:0]   wa1;
  logic [9:0]   wa2;
  logic [31:0]  wd1;
  logic [63:0]  wd2;
  logic [31:0]  pend1, pend2;
  logic         full1, full2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.NUM_SRC(4), .NUM_WPORT(1), .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush1),
    .src_valid_i(v1), .src_ready_o(rdy1), .src_waddr_i(a1), .src_wdata_i(d1),
    .reg_we_o(we1), .reg_waddr_o(wa1), .reg_wdata_o(wd1),
    .pending_o(pend1), .full_o(full1)
  );

  wb_arbiter #(.NUM_SRC(4), .NUM_WPORT(2), .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush2),
    .src_valid_i(v2), .src_ready_o(rdy2), .src_waddr_i(a2), .src_wdata_i(d2),
    .reg_we_o(we2), .reg_waddr_o(wa2), .reg_wdata_o(wd2),
    .pending_o(pend2), .full_o(full2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive1(input int s, input logic [4:0] a, input logic [31:0] d);
    v1[s] = 1'b1;
    a1[s*5 +: 5] = a;
    d1[s*32 +: 32] = d;
  endtask

  task automatic drive2(input int s, input logic [4:0] a, input logic [31:0] d);
    v2[s] = 1'b1;
    a2[s*5 +: 5] = a;
    d2[s*32 +: 32] = d;
  endtask

  // Each cycle: wait for the falling edge, drive inputs, settle, then sample
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    flush1 = 1'b0;
    flush2 = 1'b0;
    v1 = '0; a1 = '0; d1 = '0;
    v2 = '0; a2 = '0; d2 = '0;
    for (int s = 0; s < 4; s++) drive1(s, 5'(s + 1), 32'((s + 1) * 32'h11));

    repeat (2) cyc();
    #1;
    check("rst_we1", 64'(we1), 64'h0);
    check("rst_pend1", 64'(pend1), 64'h0);
    check("rst_rdy1", 64'(rdy1), 64'hF);
    check("rst_full1", 64'(full1), 64'h0);
    check("rst_we2", 64'(we2), 64'h0);
    check("rst_rdy2", 64'(rdy2), 64'hF);

`ifdef WB_ARBITER_BYPASS_EN
    v1 = '0;
    rst_n = 1'b1;

    cyc();
    drive2(2, 5'd12, 32'hDEAD);
    #1;
    check("byp_we", 64'(we2), 64'h1);
    check("byp_addr", 64'(wa2[4:0]), 64'd12);
    check("byp_data", 64'(wd2[31:0]), 64'hDEAD);
    check("byp_pend", 64'(pend2), 64'h0);

    cyc();
    v2 = '0;
    #1;
    check("byp_not_queued_we", 64'(we2), 64'h0);
    check("byp_not_queued_pend", 64'(pend2), 64'h0);

    cyc();
    drive2(2, 5'd0, 32'hBEEF);
    #1;
    check("byp_x0_we", 64'(we2), 64'h0);
    cyc();
    v2 = '0;
    #1;
    check("byp_x0_we_next", 64'(we2), 64'h0);

    cyc();
    drive2(2, 5'd13, 32'h1313);
    flush2 = 1'b1;
    #1;
    check("byp_flush_we", 64'(we2), 64'h0);
    cyc();
    v2 = '0;
    flush2 = 1'b0;
    #1;
    check("byp_flush_we_next", 64'(we2), 64'h0);
    check("byp_flush_pend", 64'(pend2), 64'h0);
`else
    // Release with all four requests held: all four push at the first edge
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      v1 = '0;
      #1;
      check($sformatf("seq_we_%0d", i), 64'(we1), 64'h1);
      check($sformatf("seq_addr_%0d", i), 64'(wa1), 64'(i + 1));
      check($sformatf("seq_data_%0d", i), 64'(wd1), 64'((i + 1) * 32'h11));
      check($sformatf("seq_pend_%0d", i), 64'(pend1),
            64'(32'h1E & ~((32'h1 << (i + 1)) - 32'h2)));
      if (i == 0) check("seq_rdy", 64'(rdy1), 64'hF);
    end
    cyc();
    #1;
    check("seq_idle_we", 64'(we1), 64'h0);
    check("seq_idle_pend", 64'(pend1), 64'h0);

    // RR pointer back at 0: source 0 wins over source 3
    drive1(0, 5'd5, 32'h55);
    drive1(3, 5'd6, 32'h66);
    cyc();
    v1 = '0;
    #1;
    check("rr_first", 64'(wa1), 64'd5);
    cyc();
    #1;
    check("rr_second", 64'(wa1), 64'd6);

    // Fill source 0 while sources 1..3 hold priority
    cyc();
    drive1(1, 5'd10, 32'hA1);
    drive1(2, 5'd11, 32'hA2);
    drive1(3, 5'd12, 32'hA3);
    #1;
    check("full_idle_we", 64'(we1), 64'h0);
    cyc();
    v1 = '0;
    drive1(0, 5'd20, 32'h20);
    #1;
    check("full_c1_addr", 64'(wa1), 64'd10);
    cyc();
    drive1(0, 5'd21, 32'h21);
    #1;
    check("full_c2_addr", 64'(wa1), 64'd11);
    check("full_c2_rdy", 64'(rdy1), 64'hF);
    cyc();
    drive1(0, 5'd22, 32'h22);
    #1;
    check("full_c3_addr", 64'(wa1), 64'd12);
    check("full_c3_rdy", 64'(rdy1), 64'hE);
    check("full_c3_full", 64'(full1), 64'h1);
    check("full_c3_pend", 64'(pend1), 64'h0030_1000);
    cyc();
    #1;
    check("full_c4_addr", 64'(wa1), 64'd20);
    check("full_c4_rdy", 64'(rdy1), 64'hE);
    check("full_c4_full", 64'(full1), 64'h1);
    cyc();
    #1;
    check("full_c5_addr", 64'(wa1), 64'd21);
    check("full_c5_rdy", 64'(rdy1), 64'hF);
    check("full_c5_full", 64'(full1), 64'h0);
    cyc();
    v1 = '0;
    #1;
    check("full_c6_we", 64'(we1), 64'h1);
    check("full_c6_addr", 64'(wa1), 64'd22);
    check("full_c6_data", 64'(wd1), 64'h22);
    cyc();
    #1;
    check("full_c7_we", 64'(we1), 64'h0);
    check("full_c7_pend", 64'(pend1), 64'h0);

    // Two sources on x7 with two ports: the later one waits a cycle
    drive2(1, 5'd7, 32'hA);
    drive2(2, 5'd7, 32'hB);
    cyc();
    v2 = '0;
    #1;
    check("conf_c1_we", 64'(we2), 64'h1);
    check("conf_c1_addr", 64'(wa2[4:0]), 64'd7);
    check("conf_c1_data", 64'(wd2[31:0]), 64'hA);
    check("conf_c1_pend7", 64'(pend2[7]), 64'h1);
    cyc();
    #1;
    check("conf_c2_we", 64'(we2), 64'h1);
    check("conf_c2_data", 64'(wd2[31:0]), 64'hB);
    check("conf_c2_pend7", 64'(pend2[7]), 64'h1);
    cyc();
    #1;
    check("conf_c3_we", 64'(we2), 64'h0);

    // RR now 3: scan wraps 3 -> 0, so port 0 gets x9 and port 1 gets x8
    drive2(0, 5'd8, 32'h8);
    drive2(3, 5'd9, 32'h9);
    cyc();
    v2 = '0;
    #1;
    check("dual_we", 64'(we2), 64'h3);
    check("dual_addr", 64'(wa2), 64'({5'd8, 5'd9}));
    check("dual_data", wd2, {32'h8, 32'h9});

    // Flush with two entries queued and a fresh push on x5
    cyc();
    drive2(0, 5'd3, 32'h3);
    drive2(1, 5'd9, 32'h9);
    cyc();
    v2 = '0;
    drive2(2, 5'd5, 32'h5);
    flush2 = 1'b1;
    #1;
    check("flush_we", 64'(we2), 64'h0);
    check("flush_pend", 64'(pend2), 64'h208);
    cyc();
    v2 = '0;
    flush2 = 1'b0;
    #1;
    check("flush_after_we", 64'(we2), 64'h0);
    check("flush_after_pend", 64'(pend2), 64'h0);
    check("flush_after_full", 64'(full2), 64'h0);
    cyc();
    #1;
    check("flush_x5_never", 64'(we2), 64'h0);

    // Without bypass the write appears one cycle after the push
    drive2(2, 5'd12, 32'hDEAD);
    #1;
    check("lat_same_we", 64'(we2), 64'h0);
    cyc();
    v2 = '0;
    #1;
    check("lat_next_we", 64'(we2), 64'h1);
    check("lat_next_addr", 64'(wa2[4:0]), 64'd12);
    check("lat_next_data", 64'(wd2[31:0]), 64'hDEAD);
    check("lat_next_pend12", 64'(pend2[12]), 64'h1);

    // A write to x0 is swallowed
    cyc();
    drive2(2, 5'd0, 32'hBEEF);
    cyc();
    v2 = '0;
    #1;
    check("x0_we", 64'(we2), 64'h0);
    check("x0_pend", 64'(pend2), 64'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Parametrised write-back arbiter; successor to the fixed four-source write-back merge.
- Collects register-write results from NUM_SRC execution sources (ALU, MULDIV, AGU, CSR, …), each through its own small in-order FIFO.
- Drives up to NUM_WPORT register-file write ports per cycle using round-robin arbitration.
- Exports a per-register pending mask so the decoder can detect RAW hazards; a flush input discards queued writes when an interrupt is taken.

Parameters:
- NUM_SRC, 4, number of result sources (2..8)
- NUM_WPORT, 1, register-file write ports driven per cycle (1..NUM_SRC)
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 2, entries per source FIFO (power of two, >=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  discard all queued and incoming writes (interrupt assert)
- src_valid_i  in  NUM_SRC  per-source write request
- src_ready_o  out  NUM_SRC  per-source FIFO not full
- src_waddr_i  in  NUM_SRC*ADDR_W  packed destination addresses, source 0 in LSBs
- src_wdata_i  in  NUM_SRC*DATA_W  packed write data
- reg_we_o  out  NUM_WPORT  write-port enables
- reg_waddr_o  out  NUM_WPORT*ADDR_W  write-port addresses
- reg_wdata_o  out  NUM_WPORT*DATA_W  write-port data
- pending_o  out  2**ADDR_W  bit r set while any queued entry targets register r
- full_o  out  1  OR of all FIFO-full flags (drives pipeline hold)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all FIFOs empty, RR pointer 0, reg_we_o=0, src_ready_o all 1, pending_o=0, full_o=0.
- Push: occurs on valid&&ready at the clock edge.
  - ready = FIFO not full. A pop in the same cycle does not raise ready.
  - waddr==0 is accepted but not stored (dropped silently).
- Latency: an entry pushed at edge N is visible on a write port in cycle N+1 at the earliest. The regfile commits it at edge N+1.
- Arbitration:
  - Candidates are non-empty FIFO heads.
  - Scan starts at the RR pointer and wraps modulo NUM_SRC.
  - The first NUM_WPORT candidates are granted, assigned to port 0, 1, … in scan order.
  - Granted heads pop at the clock edge.
  - The RR pointer moves to (last granted source + 1) mod NUM_SRC. It is unchanged if nothing is granted.
- Address conflict: if two candidates in one cycle target the same register, only the earlier in scan order is granted. The other waits, even if a port is free.
- Ordering: each source is strictly in order. No ordering is guaranteed across sources; issue logic must not send same-rd writes from different sources without a hazard check via pending_o.
- Outputs: reg_*_o are combinational from FIFO heads and grants. reg_waddr_o/reg_wdata_o are don't-care when the corresponding reg_we_o=0.
- pending_o:
  - Combinational OR over all valid FIFO entries; bit 0 is always 0.
  - An entry being popped still shows pending in its output cycle.
- flush_i:
  - In the flush cycle, reg_we_o is forced to 0 and no pops occur.
  - Pushes in the flush cycle are discarded.
  - All FIFOs are empty after the edge; pending_o=0 and full_o=0 the next cycle.
  - Flush has priority over push and pop.
- Reset mid-operation: all queued entries are lost. No write port is asserted during or after reset until a new push.
- Pointer wrap: FIFO read/write pointers are log2(FIFO_DEPTH)+1 bits; full/empty are decided by MSB comparison.

Optional Feature:
- Macro: WB_ARBITER_BYPASS_EN.
- Enabled:
  - A source whose FIFO is empty and whose valid request is granted (same RR/conflict rules, the request counts as a candidate) drives the write port in the same cycle and is not enqueued. Latency is 0.
  - pending_o does not include bypassed entries.
  - Flush suppresses the bypass.
- Disabled: every write passes through the FIFO (latency 1).

Decomposition:
- Package wb_arbiter_pkg:
  - typedef wb_entry_t (addr ADDR_W, data DATA_W), using default widths 5/32
  - localparams for RR pointer width and FIFO pointer width
  - function rr_next(ptr, grant_mask)
- Sub-module wb_fifo: one synchronous FIFO per source.
  - Ports: push, pop, flush.
  - Outputs: head, full, empty, valid-entry vector (feeds pending_o).

Test Plan:
- Reset with src_valid_i=4'b1111 held -> during reset, reg_we_o=0, pending_o=0, src_ready_o=4'b1111. After release, four pushes are accepted at the first edge.
- NUM_WPORT=1; sources 0..3 push x1..x4 with data 0x11..0x44 in one cycle -> writes appear on four consecutive cycles in order x1,x2,x3,x4. The RR pointer ends at 0.
- Sources 1 and 2 both target x7 (data 0xA, 0xB), NUM_WPORT=2, RR=0 -> cycle 1 writes x7=0xA only. Cycle 2 writes x7=0xB. pending_o[7] stays 1 through cycle 2.
- Source 0 pushes three times with FIFO_DEPTH=2 and no grant (other sources hold priority) -> src_ready_o[0]=0 and full_o=1 after two pushes. The third push is held until a pop.
- Two entries queued on x3 and x9, then flush_i pulsed for one cycle with a new push on x5 -> no write-port activity. The next cycle shows pending_o=0 and full_o=0. x5 is never written.
- WB_ARBITER_BYPASS_EN defined, empty FIFOs, source 2 pushes x12=0xDEAD -> reg_we_o[0]=1, reg_waddr_o=12, reg_wdata_o=0xDEAD in the same cycle, with pending_o[12]=0. Repeating the push to x0 -> no write.
